frogger_lane_renderer: RTL

- Parametrised, clocked successor to the combinational frogger scene colour mux.
- Owns NUM_LANES scrolling obstacle lanes, each with its own speed and direction.
- Owns a countdown time bar that shrinks over the round.
- Detects frog/obstacle overlap, reported per frame.
- Feeds the 6-bit colorcode into the existing palette/VGA path. The frog sprite lookup stays upstream.

---
 rtl/frogger_pkg.sv | 26 ++
 rtl/frogger_lane_ctr.sv | 48 ++++
 rtl/frogger_lane_renderer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/frogger_pkg.sv
// frogger_pkg: shared definitions for the frogger lane renderer.
//   - coord_t: 10-bit screen coordinate type.
//   - Colour codes for the downstream palette (6-bit colorcode values).
//   - Time bar geometry (origin and height).
// Optional build macro used elsewhere in this slice: LANE_STRIPES_EN.
package frogger_pkg;

    typedef logic [9:0] coord_t;

    localparam logic [5:0] C_WHITE  = 6'd0;
    localparam logic [5:0] C_BLACK  = 6'd1;
    localparam logic [5:0] C_GREEN  = 6'd2;
    localparam logic [5:0] C_RED    = 6'd3;
    localparam logic [5:0] C_LBLUE  = 6'd4;
    localparam logic [5:0] C_YELLOW = 6'd5;
    localparam logic [5:0] C_GREY   = 6'd6;
    localparam logic [5:0] C_ORANGE = 6'd7;
    localparam logic [5:0] C_BROWN  = 6'd8;
    localparam logic [5:0] C_PURPLE = 6'd9;
    localparam logic [5:0] C_DBLUE  = 6'd10;

    localparam int TBAR_X = 430;
    localparam int TBAR_Y = 460;
    localparam int TBAR_H = 15;

endpackage

// File: rtl/frogger_lane_ctr.sv
// frogger_lane_ctr: scroll offset register for one obstacle lane.
// Ports:
//   Clk         pixel clock
//   Reset_n     asynchronous active-low reset (offset returns to 0)
//   frame_start one-cycle pulse; offset advances by speed in direction dir
//   speed       px per frame (0..15)
//   dir         0 = scroll right (add), 1 = scroll left (subtract)
//   off         current offset, always in 0..SCREEN_W-1
module frogger_lane_ctr
    import frogger_pkg::*;
#(
    parameter int SCREEN_W = 640
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_start,
    input  logic [3:0] speed,
    input  logic       dir,
    output coord_t     off
);

    localparam logic [10:0] SW = 11'(SCREEN_W);

    logic [10:0] fwd;
    logic [10:0] bwd;
    coord_t      off_next;

    // Speed is far below SCREEN_W, so one compare-and-correct keeps the
    // offset inside 0..SCREEN_W-1 in either direction.
    assign fwd = {1'b0, off} + {7'b0, speed};
    assign bwd = {1'b0, off} - {7'b0, speed};

    always_comb begin
        off_next = off;
        if (!dir)
            off_next = coord_t'((fwd >= SW) ? (fwd - SW) : fwd);
        else
            off_next = coord_t'((off < coord_t'(speed)) ? (bwd + SW) : bwd);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            off <= '0;
        else if (frame_start)
            off <= off_next;
    end

endmodule

// File: rtl/frogger_lane_renderer.sv
// frogger_lane_renderer: clocked scene colour generator for the frogger road.
// Owns NUM_LANES scrolling obstacle lanes, a countdown time bar and a
// per-frame frog/obstacle collision flag. colorcode is registered (1 cycle
// latency from DrawX/DrawY).
// Ports:
//   Clk, Reset_n      pixel clock, asynchronous active-low reset
//   frame_start       one-cycle pulse at start of vertical blank
//   round_restart     reloads the time bar, clears collision state
//   DrawX, DrawY      current pixel
//   FrogX, FrogY      frog box top-left corner
//   frog_pixel        upstream sprite colour; BLACK (1) is transparent
//   lane_speed        4 bits per lane, lane i at [4i+3:4i]
//   lane_dir          bit i: 0 = right, 1 = left
//   colorcode         registered pixel colour
//   time_width        time bar width in px
//   time_up           one-cycle pulse when time_width reaches 0
//   collision         frog hit an obstacle during the previous frame
// Build macro: LANE_STRIPES_EN adds white dashed lane boundary stripes.
module frogger_lane_renderer
    import frogger_pkg::*;
#(
    parameter int NUM_LANES        = 4,
    parameter int LANE_Y0          = 280,
    parameter int LANE_HEIGHT      = 32,
    parameter int SCREEN_W         = 640,
    parameter int OBJ_PERIOD_LOG2  = 7,
    parameter int OBJ_LEN          = 40,
    parameter int OBJ_MARGIN       = 4,
    parameter int FROG_W           = 17,
    parameter int FROG_H           = 16,
    parameter int TIME_BAR_MAX     = 200,
    parameter int TIME_TICK_FRAMES = 15
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   frame_start,
    input  logic                   round_restart,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    input  logic [9:0]             FrogX,
    input  logic [9:0]             FrogY,
    input  logic [5:0]             frog_pixel,
    input  logic [4*NUM_LANES-1:0] lane_speed,
    input  logic [NUM_LANES-1:0]   lane_dir,
    output logic [5:0]             colorcode,
    output coord_t                 time_width,
    output logic                   time_up,
    output logic                   collision
);

    localparam logic [10:0] SW      = 11'(SCREEN_W);
    localparam logic [10:0] PMASK   = 11'((1 << OBJ_PERIOD_LOG2) - 1);
    localparam logic [10:0] OBJ_L   = 11'(OBJ_LEN);
    localparam int          DIV_W   = (TIME_TICK_FRAMES > 1) ? $clog2(TIME_TICK_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TIME_TICK_FRAMES - 1);

    coord_t               lane_off [NUM_LANES];
    logic [NUM_LANES-1:0] lane_hit;
`ifdef LANE_STRIPES_EN
    logic [NUM_LANES-1:0] lane_stripe;
`endif

    logic [10:0]      dx;
    logic [10:0]      dy;
    logic             in_frog_box;
    logic             frog_vis;
    logic             in_tbar;
    logic             coincide;
    logic [5:0]       color_next;
    logic [DIV_W-1:0] frame_div;
    logic             hit_pending;

    assign dx = {1'b0, DrawX};
    assign dy = {1'b0, DrawY};

    // Per-lane offset counter and hit test on the current pixel.
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        localparam int TOP = LANE_Y0 + gi * LANE_HEIGHT;

        logic [10:0] s_raw;
        logic [10:0] s_wrap;
        logic        row_ok;

        frogger_lane_ctr #(
            .SCREEN_W (SCREEN_W)
        ) u_ctr (
            .Clk         (Clk),
            .Reset_n     (Reset_n),
            .frame_start (frame_start),
            .speed       (lane_speed[4*gi +: 4]),
            .dir         (lane_dir[gi]),
            .off         (lane_off[gi])
        );

        assign s_raw  = dx + {1'b0, lane_off[gi]};
        assign s_wrap = (s_raw >= SW) ? (s_raw - SW) : s_raw;
        assign row_ok = (dy >= 11'(TOP + OBJ_MARGIN)) &&
                        (dy <  11'(TOP + LANE_HEIGHT - OBJ_MARGIN));
        // Position within the repeating obstacle period.
        assign lane_hit[gi] = row_ok && ((s_wrap & PMASK) < OBJ_L);

`ifdef LANE_STRIPES_EN
        if (gi >= 1) begin : g_stripe
            assign lane_stripe[gi] = (dy >= 11'(TOP)) && (dy < 11'(TOP + 2)) && !DrawX[6];
        end else begin : g_no_stripe
            assign lane_stripe[gi] = 1'b0;
        end
`endif
    end

    assign in_frog_box = (DrawX >= FrogX) && (dx < ({1'b0, FrogX} + 11'(FROG_W))) &&
                         (DrawY >= FrogY) && (dy < ({1'b0, FrogY} + 11'(FROG_H)));
    assign frog_vis    = in_frog_box && (frog_pixel != C_BLACK);
    assign in_tbar     = (dx >= 11'(TBAR_X)) && (dx < (11'(TBAR_X) + {1'b0, time_width})) &&
                         (dy >= 11'(TBAR_Y)) && (dy < 11'(TBAR_Y + TBAR_H));
    assign coincide    = frog_vis && (|lane_hit);

    always_comb begin
        color_next = C_GREY;
        if (frog_vis)
            color_next = frog_pixel;
        else if (in_tbar)
            color_next = C_GREEN;
`ifdef LANE_STRIPES_EN
        else if (|lane_stripe)
            color_next = C_WHITE;
`endif
        else if (|lane_hit)
            color_next = C_RED;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            colorcode <= C_GREY;
        else
            colorcode <= color_next;
    end

    // Time bar: one px lost every TIME_TICK_FRAMES frames, saturating at 0.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            time_width <= coord_t'(TIME_BAR_MAX);
            frame_div  <= '0;
            time_up    <= 1'b0;
        end else begin
            time_up <= 1'b0;
            if (round_restart) begin
                time_width <= coord_t'(TIME_BAR_MAX);
                frame_div  <= '0;
            end else if (frame_start) begin
                if (frame_div == DIV_LAST) begin
                    frame_div <= '0;
                    if (time_width != '0) begin
                        time_width <= time_width - coord_t'(1);
                        time_up    <= (time_width == coord_t'(1));
                    end
                end else begin
                    frame_div <= frame_div + DIV_W'(1);
                end
            end
        end
    end

    // Collision: accumulate over a frame, publish at frame_start. A
    // coincidence on the frame_start cycle belongs to the new frame.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit_pending <= 1'b0;
            collision   <= 1'b0;
        end else if (round_restart) begin
            hit_pending <= 1'b0;
            collision   <= 1'b0;
        end else if (frame_start) begin
            collision   <= hit_pending;
            hit_pending <= coincide;
        end else if (coincide) begin
            hit_pending <= 1'b1;
        end
    end

endmodule
